spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: memory-mapped SPI responder with 8-bit MSB-first frames.
// The external SCLK/SS/MOSI pins are synchronised into clk_i, edges are
// detected in the clk_i domain, and a two-state frame FSM shifts a byte
// out of TXDATA while capturing a byte into RXDATA. All four CPOL/CPHA
// modes are supported. Bus side: single-cycle we_i/addr_i/data_i write
// port and combinational data_o read port.

module spi_slave (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    input  logic        spi_sclk,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq_o
);

    // Register offsets (addr_i[3:0])
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_TXDATA = 4'h4;
    localparam logic [3:0] ADDR_RXDATA = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_ctrl;        // {irq_en, cpha, cpol, en}
    logic [7:0]  r_txdata;
    logic [7:0]  r_rxdata;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_tx_empty;

    logic [2:0]  r_sclk_sync;   // [0],[1] synchroniser, [2] edge-detect history
    logic [2:0]  r_ss_sync;
    logic [1:0]  r_mosi_sync;

    logic [7:0]  r_tx_shift;    // bits still to be driven, next one in [7]
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_miso;
    logic        r_rx_done;     // one-cycle pulse: rx_shift holds a full byte

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t      w_state_next;
    logic        w_en;
    logic        w_cpol;
    logic        w_cpha;
    logic        w_irq_en;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_lead;
    logic        w_trail;

    logic        w_start;       // IDLE -> ACTIVE this cycle
    logic        w_stop;        // ACTIVE -> IDLE this cycle
    logic        w_sample;      // capture MOSI this cycle
    logic        w_drive;       // shift next TX bit onto MISO this cycle
    logic        w_busy;
    logic        w_byte_done;
    logic        w_load;

    logic        w_wr_ctrl;
    logic        w_wr_tx;
    logic        w_wr_status;
    logic        w_clr_rx_valid;
    logic        w_clr_overrun;

    logic        w_unused_bits;

    assign w_en     = r_ctrl[0];
    assign w_cpol   = r_ctrl[1];
    assign w_cpha   = r_ctrl[2];
    assign w_irq_en = r_ctrl[3];

    // Upper bus bits are not decoded
    assign w_unused_bits = ^{data_i[31:8], addr_i[31:4]};

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ------------------------------------------------------------------
    // Two-flop synchronisers on all pins plus a third history flop on SCLK/SS.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours (a shift chain with
    // blocking assignments would collapse into a single flop).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk_sync <= 3'b000;
            r_ss_sync   <= 3'b111;   // deselected, so no false SS fall after reset
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
            r_ss_sync   <= {r_ss_sync[1:0], spi_ss_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];

    // Leading edge leaves the idle level, trailing edge returns to it
    assign w_lead  = w_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail = w_cpol ? w_sclk_rise : w_sclk_fall;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: enter on SS fall while enabled, leave on SS rise or disable.
    // NOTE: every signal driven in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_en && w_ss_fall) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!w_en || w_ss_rise) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: per-cycle shift/sample strobes chosen by CPHA.
    always_comb begin
        w_start  = 1'b0;
        w_stop   = 1'b0;
        w_sample = 1'b0;
        w_drive  = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = w_en && w_ss_fall;
            end
            ST_ACTIVE: begin
                w_busy = 1'b1;
                if (!w_en || w_ss_rise) begin
                    w_stop = 1'b1;
                end else begin
                    w_sample = w_cpha ? w_trail : w_lead;
                    w_drive  = w_cpha ? w_lead  : w_trail;
                end
            end
            default: ;
        endcase
    end

    assign w_byte_done = w_sample && (r_bit_cnt == 3'd7);
    assign w_load      = w_start || w_byte_done;

    assign spi_miso_oe = w_busy;
    assign spi_miso    = r_miso;

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    // TX/RX shifters and bit counter. With CPHA=0 bit 7 goes out at entry,
    // so the shifter is loaded pre-shifted; after a mid-frame reload the
    // next trailing edge drives the new bit 7 through the normal drive path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_shift <= 8'h00;
            r_rx_shift <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_miso     <= 1'b0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_done <= w_byte_done;
            if (w_start) begin
                r_bit_cnt <= 3'd0;
                if (w_cpha) begin
                    r_tx_shift <= r_txdata;
                end else begin
                    r_tx_shift <= {r_txdata[6:0], 1'b0};
                    r_miso     <= r_txdata[7];
                end
            end else if (w_stop) begin
                r_bit_cnt <= 3'd0;
            end else begin
                if (w_sample) begin
                    r_rx_shift <= {r_rx_shift[6:0], r_mosi_sync[1]};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;   // wraps to 0 after bit 8
                    if (w_byte_done) begin
                        r_tx_shift <= r_txdata;
                    end
                end
                if (w_drive) begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus registers
    // ------------------------------------------------------------------
    assign w_wr_ctrl      = we_i && (addr_i[3:0] == ADDR_CTRL);
    assign w_wr_tx        = we_i && (addr_i[3:0] == ADDR_TXDATA);
    assign w_wr_status    = we_i && (addr_i[3:0] == ADDR_STATUS);
    assign w_clr_rx_valid = w_wr_status && data_i[1];
    assign w_clr_overrun  = w_wr_status && data_i[2];

    // Control/data registers and status flags; hardware sets win over W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl     <= 4'h0;
            r_txdata   <= 8'h00;
            r_rxdata   <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_empty <= 1'b1;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= data_i[3:0];
            end
            if (w_wr_tx) begin
                r_txdata <= data_i[7:0];
            end

            // A bus write refills TXDATA even if the shifter loads this cycle
            if (w_wr_tx) begin
                r_tx_empty <= 1'b0;
            end else if (w_load) begin
                r_tx_empty <= 1'b1;
            end

            if (r_rx_done) begin
                r_rxdata   <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_clr_rx_valid) begin
                r_rx_valid <= 1'b0;
            end

            // Overrun only if the previous byte is still unacknowledged
            if (r_rx_done && r_rx_valid && !w_clr_rx_valid) begin
                r_overrun <= 1'b1;
            end else if (w_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Read mux: combinational from current register state.
    always_comb begin
        data_o = 32'h0;
        case (addr_i[3:0])
            ADDR_CTRL:   data_o[3:0] = r_ctrl;
            ADDR_TXDATA: data_o[7:0] = r_txdata;
            ADDR_RXDATA: data_o[7:0] = r_rxdata;
            ADDR_STATUS: data_o[3:0] = {r_tx_empty, r_overrun, r_rx_valid, w_busy};
            default:     data_o      = 32'h0;
        endcase
    end

    assign irq_o = r_rx_valid & w_irq_en;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: a behavioural SPI controller drives the
// pins at clk/16 while tasks exercise each feature and compare against
// hand-computed values.

module tb_spi_slave;

    localparam int HALF = 8;   // SCLK half period in clk_i cycles

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        spi_sclk;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        irq_o;

    logic        cpol;
    logic        cpha;
    int          checks = 0;
    int          errors = 0;

    spi_slave dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .data_o      (data_o),
        .spi_sclk    (spi_sclk),
        .spi_ss_n    (spi_ss_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_i);
        addr_i = {28'h0, a};
        data_i = d;
        we_i   = 1'b1;
        @(negedge clk_i);
        we_i   = 1'b0;
        data_i = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_i);
        addr_i = {28'h0, a};
        #1;
        d = data_o;
    endtask

    task automatic set_mode(input logic cpol_v, input logic cpha_v);
        cpol     = cpol_v;
        cpha     = cpha_v;
        spi_sclk = cpol_v;
        bus_write(4'h0, {28'h0, 1'b1, cpha_v, cpol_v, 1'b1});
        wait_clk(HALF);
    endtask

    task automatic ss_low;
        spi_ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high;
        spi_ss_n = 1'b1;
        wait_clk(HALF);
    endtask

    // Controller side: shift nbits MSB first, returning what MISO carried.
    task automatic shift_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                spi_mosi = tx[7-i];
                wait_clk(HALF);
                spi_sclk = ~cpol;
                rx[7-i]  = spi_miso;
                wait_clk(HALF);
                spi_sclk = cpol;
            end else begin
                spi_sclk = ~cpol;
                spi_mosi = tx[7-i];
                wait_clk(HALF);
                spi_sclk = cpol;
                rx[7-i]  = spi_miso;
                wait_clk(HALF);
            end
        end
        if (!cpha) wait_clk(HALF);
    endtask

    task automatic spi_frame(input logic [7:0] tx, output logic [7:0] rx);
        ss_low();
        shift_bits(tx, 8, rx);
        ss_high();
        wait_clk(4);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        logic [31:0] d;
        rst_i    = 1'b1;
        we_i     = 1'b0;
        addr_i   = 32'h0;
        data_i   = 32'h0;
        spi_sclk = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        wait_clk(4);
        rst_i = 1'b0;
        wait_clk(2);

        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h8); end
        bus_read(4'h0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", d, 32'h0); end
        bus_read(4'h4, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_txdata got %h exp %h", d, 32'h0); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rxdata got %h exp %h", d, 32'h0); end
        bus_read(4'h1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_unmapped got %h exp %h", d, 32'h0); end
        checks++;
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", spi_miso_oe); end
        checks++;
        if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_o); end
    endtask

    task automatic test_mode0;
        logic [31:0] d;
        logic [7:0]  rx;
        set_mode(1'b0, 1'b0);
        bus_read(4'h0, d);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL m0_ctrl got %h exp %h", d, 32'h9); end
        bus_write(4'h4, 32'hA5);
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL m0_status_txfull got %h exp %h", d, 32'h0); end

        spi_frame(8'h3C, rx);
        checks++;
        if (rx !== 8'hA5) begin errors++; $display("FAIL m0_miso_byte got %h exp %h", rx, 8'hA5); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL m0_rxdata got %h exp %h", d, 32'h3C); end
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'hA) begin errors++; $display("FAIL m0_status got %h exp %h", d, 32'hA); end
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL m0_irq_set got %b exp 1", irq_o); end

        // RXDATA is read-only
        bus_write(4'h8, 32'hFF);
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL m0_rxdata_ro got %h exp %h", d, 32'h3C); end

        bus_write(4'hC, 32'h2);
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL m0_status_w1c got %h exp %h", d, 32'h8); end
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL m0_irq_clr got %b exp 0", irq_o); end
    endtask

    task automatic test_modes;
        logic [31:0] d;
        logic [7:0]  rx;
        logic [1:0]  mb;
        for (int m = 1; m <= 3; m++) begin
            mb = m[1:0];
            set_mode(mb[1], mb[0]);
            bus_write(4'h4, 32'h5A);
            spi_frame(8'hC3, rx);
            checks++;
            if (rx !== 8'h5A) begin errors++; $display("FAIL mode%0d_miso_byte got %h exp %h", m, rx, 8'h5A); end
            bus_read(4'h8, d);
            checks++;
            if (d !== 32'hC3) begin errors++; $display("FAIL mode%0d_rxdata got %h exp %h", m, d, 32'hC3); end
            bus_write(4'hC, 32'h2);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [7:0]  rx1;
        logic [7:0]  rx2;
        set_mode(1'b0, 1'b0);
        bus_write(4'h4, 32'h96);
        ss_low();
        shift_bits(8'h11, 8, rx1);
        shift_bits(8'h22, 8, rx2);
        ss_high();
        wait_clk(4);
        checks++;
        if (rx1 !== 8'h96) begin errors++; $display("FAIL b2b_miso_first got %h exp %h", rx1, 8'h96); end
        checks++;
        if (rx2 !== 8'h96) begin errors++; $display("FAIL b2b_miso_stale got %h exp %h", rx2, 8'h96); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL b2b_rxdata got %h exp %h", d, 32'h22); end
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'hE) begin errors++; $display("FAIL b2b_status_overrun got %h exp %h", d, 32'hE); end
        bus_write(4'hC, 32'h6);
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL b2b_status_clear got %h exp %h", d, 32'h8); end
    endtask

    task automatic test_partial_frame;
        logic [31:0] d;
        logic [7:0]  rx;
        ss_low();
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL partial_busy got %h exp %h", d, 32'h9); end
        checks++;
        if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL partial_oe got %b exp 1", spi_miso_oe); end
        shift_bits(8'hFF, 5, rx);
        ss_high();
        wait_clk(4);
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL partial_status got %h exp %h", d, 32'h8); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL partial_rxdata got %h exp %h", d, 32'h22); end

        bus_write(4'h4, 32'h81);
        spi_frame(8'h7E, rx);
        checks++;
        if (rx !== 8'h81) begin errors++; $display("FAIL partial_next_miso got %h exp %h", rx, 8'h81); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h7E) begin errors++; $display("FAIL partial_next_rxdata got %h exp %h", d, 32'h7E); end
        bus_write(4'hC, 32'h2);
    endtask

    task automatic test_enable_clear;
        logic [31:0] d;
        logic [7:0]  rx;
        ss_low();
        shift_bits(8'hAA, 3, rx);
        checks++;
        if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL en_oe_before got %b exp 1", spi_miso_oe); end
        bus_write(4'h0, 32'h0);
        wait_clk(1);
        checks++;
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL en_oe_drop got %b exp 0", spi_miso_oe); end
        ss_high();

        // Disabled: a complete frame must be ignored
        ss_low();
        checks++;
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL en_off_oe got %b exp 0", spi_miso_oe); end
        shift_bits(8'h55, 8, rx);
        ss_high();
        wait_clk(4);
        bus_read(4'hC, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL en_off_status got %h exp %h", d, 32'h8); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h7E) begin errors++; $display("FAIL en_off_rxdata got %h exp %h", d, 32'h7E); end

        // Re-enabled: frames work again
        set_mode(1'b0, 1'b0);
        bus_write(4'h4, 32'h3C);
        spi_frame(8'h99, rx);
        checks++;
        if (rx !== 8'h3C) begin errors++; $display("FAIL en_on_miso got %h exp %h", rx, 8'h3C); end
        bus_read(4'h8, d);
        checks++;
        if (d !== 32'h99) begin errors++; $display("FAIL en_on_rxdata got %h exp %h", d, 32'h99); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_partial_frame();
        test_enable_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
